// File: rtl/rs_alu_pkg.sv
// ============================================================================
// rs_alu_pkg : shared op codes and sizing for the reservation station + ALU
// Rev 1.0
// ============================================================================
`default_nettype none

package rs_alu_pkg;

  localparam int RS_SIZE_DEF   = 8;
  localparam int ROB_WIDTH_DEF = 3;
  localparam int OP_W          = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_SLTIU = 6'd13,
    OP_XORI  = 6'd14,
    OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16,
    OP_SLLI  = 6'd17,
    OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_ADD   = 6'd20,
    OP_SUB   = 6'd21,
    OP_SLL   = 6'd22,
    OP_SLT   = 6'd23,
    OP_SLTU  = 6'd24,
    OP_XOR   = 6'd25,
    OP_SRL   = 6'd26,
    OP_SRA   = 6'd27,
    OP_OR    = 6'd28,
    OP_AND   = 6'd29
  } op_e;

endpackage

`default_nettype wire

// File: rtl/rs_alu_alu.sv
// ============================================================================
// alu : single-cycle combinational integer ALU used by rs_alu dispatch
// Rev 1.0
// ============================================================================
`default_nettype none

module alu
  import rs_alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     vj,
  input  logic [31:0]     vk,
  input  logic [31:0]     imm,
  input  logic [31:0]     pc,
  output logic [31:0]     result
);

  always_comb begin
    result = 32'd0;
    case (op)
      OP_LUI:   result = imm;
      OP_AUIPC: result = pc + imm;
      OP_JAL,
      OP_JALR:  result = pc + 32'd4;
      // branches report the taken decision, not a target
      OP_BEQ:   result = {31'd0, vj == vk};
      OP_BNE:   result = {31'd0, vj != vk};
      OP_BLT:   result = {31'd0, $signed(vj) < $signed(vk)};
      OP_BGE:   result = {31'd0, $signed(vj) >= $signed(vk)};
      OP_BLTU:  result = {31'd0, vj < vk};
      OP_BGEU:  result = {31'd0, vj >= vk};
      OP_ADDI:  result = vj + imm;
      OP_SLTI:  result = {31'd0, $signed(vj) < $signed(imm)};
      OP_SLTIU: result = {31'd0, vj < imm};
      OP_XORI:  result = vj ^ imm;
      OP_ORI:   result = vj | imm;
      OP_ANDI:  result = vj & imm;
      OP_SLLI:  result = vj << imm[4:0];
      OP_SRLI:  result = vj >> imm[4:0];
      OP_SRAI:  result = 32'($signed(vj) >>> imm[4:0]);
      OP_ADD:   result = vj + vk;
      OP_SUB:   result = vj - vk;
      OP_SLL:   result = vj << vk[4:0];
      OP_SLT:   result = {31'd0, $signed(vj) < $signed(vk)};
      OP_SLTU:  result = {31'd0, vj < vk};
      OP_XOR:   result = vj ^ vk;
      OP_SRL:   result = vj >> vk[4:0];
      OP_SRA:   result = 32'($signed(vj) >>> vk[4:0]);
      OP_OR:    result = vj | vk;
      OP_AND:   result = vj & vk;
      default:  result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rs_alu.sv
// ============================================================================
// rs_alu : reservation station with operand wakeup feeding one ALU per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE       = RS_SIZE_DEF,
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [OP_W-1:0]          issue_op,
  input  logic [31:0]              issue_pc,
  input  logic [31:0]              issue_imm,
  input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  input  logic                     issue_rj,
  input  logic                     issue_rk,
  input  logic [31:0]              issue_vj,
  input  logic [31:0]              issue_vk,
  input  logic [ROB_WIDTH_BIT-1:0] issue_qj,
  input  logic [ROB_WIDTH_BIT-1:0] issue_qk,
  output logic                     rs_full,
  input  logic                     lsb_to_rob,
  input  logic [31:0]              lsb_value,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_dest,
  input  logic                     clear_all,
  output logic                     rs_to_rob,
  output logic [31:0]              rs_value,
  output logic [ROB_WIDTH_BIT-1:0] rs_dest
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]       busy_q, busy_d;
  logic [OP_W-1:0]          op_q  [RS_SIZE];
  logic [OP_W-1:0]          op_d  [RS_SIZE];
  logic [31:0]              pc_q  [RS_SIZE];
  logic [31:0]              pc_d  [RS_SIZE];
  logic [31:0]              imm_q [RS_SIZE];
  logic [31:0]              imm_d [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] rob_q [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] rob_d [RS_SIZE];
  logic [31:0]              vj_q  [RS_SIZE];
  logic [31:0]              vj_d  [RS_SIZE];
  logic [31:0]              vk_q  [RS_SIZE];
  logic [31:0]              vk_d  [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] qj_q  [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] qj_d  [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] qk_q  [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] qk_d  [RS_SIZE];
  logic [RS_SIZE-1:0]       rj_q, rj_d, rk_q, rk_d;

  logic                     rs_to_rob_q, rs_to_rob_d;
  logic [31:0]              rs_value_q, rs_value_d;
  logic [ROB_WIDTH_BIT-1:0] rs_dest_q, rs_dest_d;

  logic [IDX_W-1:0]         free_idx, disp_idx;
  logic                     disp_any;
  logic [31:0]              alu_result;

  assign rs_full   = &busy_q;
  assign rs_to_rob = rs_to_rob_q;
  assign rs_value  = rs_value_q;
  assign rs_dest   = rs_dest_q;

  function automatic logic tag_hit(input logic                     valid,
                                   input logic [ROB_WIDTH_BIT-1:0] a,
                                   input logic [ROB_WIDTH_BIT-1:0] b);
    return valid && (a == b);
  endfunction

  // Lowest-index priority encoders for the free slot and the dispatch slot.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    disp_any = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
      end
      if (busy_q[i] && rj_q[i] && rk_q[i]) begin
        disp_idx = IDX_W'(i);
        disp_any = 1'b1;
      end
    end
  end

  alu u_alu (
    .op     (op_q[disp_idx]),
    .vj     (vj_q[disp_idx]),
    .vk     (vk_q[disp_idx]),
    .imm    (imm_q[disp_idx]),
    .pc     (pc_q[disp_idx]),
    .result (alu_result)
  );

  always_comb begin
    busy_d      = busy_q;
    op_d        = op_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rob_d       = rob_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    rj_d        = rj_q;
    rk_d        = rk_q;
    rs_to_rob_d = rs_to_rob_q;
    rs_value_d  = rs_value_q;
    rs_dest_d   = rs_dest_q;

    if (rdy_in) begin
      if (clear_all) begin
        busy_d      = '0;
        rs_to_rob_d = 1'b0;
      end else begin
        // LSB is checked first so it wins when both buses carry the same tag.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && !rj_q[i]) begin
            if (tag_hit(lsb_to_rob, lsb_dest, qj_q[i])) begin
              vj_d[i] = lsb_value;
              rj_d[i] = 1'b1;
            end else if (tag_hit(rs_to_rob_q, rs_dest_q, qj_q[i])) begin
              vj_d[i] = rs_value_q;
              rj_d[i] = 1'b1;
            end
          end
          if (busy_q[i] && !rk_q[i]) begin
            if (tag_hit(lsb_to_rob, lsb_dest, qk_q[i])) begin
              vk_d[i] = lsb_value;
              rk_d[i] = 1'b1;
            end else if (tag_hit(rs_to_rob_q, rs_dest_q, qk_q[i])) begin
              vk_d[i] = rs_value_q;
              rk_d[i] = 1'b1;
            end
          end
        end

        rs_to_rob_d = disp_any;
        if (disp_any) begin
          busy_d[disp_idx] = 1'b0;
          rs_value_d       = alu_result;
          rs_dest_d        = rob_q[disp_idx];
        end

        if (issue_valid && !rs_full) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = issue_op;
          pc_d[free_idx]   = issue_pc;
          imm_d[free_idx]  = issue_imm;
          rob_d[free_idx]  = issue_rob_id;
          qj_d[free_idx]   = issue_qj;
          qk_d[free_idx]   = issue_qk;
          vj_d[free_idx]   = issue_vj;
          vk_d[free_idx]   = issue_vk;
          rj_d[free_idx]   = issue_rj;
          rk_d[free_idx]   = issue_rk;
          if (!issue_rj) begin
            if (tag_hit(lsb_to_rob, lsb_dest, issue_qj)) begin
              vj_d[free_idx] = lsb_value;
              rj_d[free_idx] = 1'b1;
            end else if (tag_hit(rs_to_rob_q, rs_dest_q, issue_qj)) begin
              vj_d[free_idx] = rs_value_q;
              rj_d[free_idx] = 1'b1;
            end
          end
          if (!issue_rk) begin
            if (tag_hit(lsb_to_rob, lsb_dest, issue_qk)) begin
              vk_d[free_idx] = lsb_value;
              rk_d[free_idx] = 1'b1;
            end else if (tag_hit(rs_to_rob_q, rs_dest_q, issue_qk)) begin
              vk_d[free_idx] = rs_value_q;
              rk_d[free_idx] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      rs_to_rob_q <= 1'b0;
      rs_value_q  <= 32'd0;
      rs_dest_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      rs_to_rob_q <= rs_to_rob_d;
      rs_value_q  <= rs_value_d;
      rs_dest_q   <= rs_dest_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    op_q  <= op_d;
    pc_q  <= pc_d;
    imm_q <= imm_d;
    rob_q <= rob_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    rj_q  <= rj_d;
    rk_q  <= rk_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_rs_alu.sv
// ============================================================================
// tb_rs_alu : self-checking bench for rs_alu (vector table, sequences, random)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue_valid, issue_rj, issue_rk;
  logic [5:0]  issue_op;
  logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk, lsb_value;
  logic [2:0]  issue_rob_id, issue_qj, issue_qk, lsb_dest;
  logic        rs_full, lsb_to_rob, clear_all, rs_to_rob;
  logic [31:0] rs_value;
  logic [2:0]  rs_dest;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_rob_id(issue_rob_id),
    .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .rs_full(rs_full),
    .lsb_to_rob(lsb_to_rob), .lsb_value(lsb_value), .lsb_dest(lsb_dest),
    .clear_all(clear_all),
    .rs_to_rob(rs_to_rob), .rs_value(rs_value), .rs_dest(rs_dest)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc, exp;
  } vec_t;
  vec_t vecs[$];

  // Reference ALU written directly from the op semantics.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic [31:0] pc);
    int signed sa = a, sb = b, si = imm;
    case (op)
      OP_LUI:   return imm;
      OP_AUIPC: return pc + imm;
      OP_JAL, OP_JALR: return pc + 4;
      OP_BEQ:   return (a == b) ? 1 : 0;
      OP_BNE:   return (a != b) ? 1 : 0;
      OP_BLT:   return (sa < sb) ? 1 : 0;
      OP_BGE:   return (sa >= sb) ? 1 : 0;
      OP_BLTU:  return (a < b) ? 1 : 0;
      OP_BGEU:  return (a >= b) ? 1 : 0;
      OP_ADDI:  return a + imm;
      OP_SLTI:  return (sa < si) ? 1 : 0;
      OP_SLTIU: return (a < imm) ? 1 : 0;
      OP_XORI:  return a ^ imm;
      OP_ORI:   return a | imm;
      OP_ANDI:  return a & imm;
      OP_SLLI:  return a << (imm % 32);
      OP_SRLI:  return a >> (imm % 32);
      OP_SRAI:  return sa >>> (imm % 32);
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SLL:   return a << (b % 32);
      OP_SLT:   return (sa < sb) ? 1 : 0;
      OP_SLTU:  return (a < b) ? 1 : 0;
      OP_XOR:   return a ^ b;
      OP_SRL:   return a >> (b % 32);
      OP_SRA:   return sa >>> (b % 32);
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      default:  return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [2:0] rob, input logic rj, input logic [31:0] vj,
                             input logic [2:0] qj, input logic rk, input logic [31:0] vk,
                             input logic [2:0] qk);
    issue_valid = 1'b1; issue_op = op; issue_pc = pc; issue_imm = imm;
    issue_rob_id = rob; issue_rj = rj; issue_vj = vj; issue_qj = qj;
    issue_rk = rk; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; idle(); lsb_to_rob = 1'b0; clear_all = 1'b0; rdy_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  initial begin
    logic       exp_prev_v;
    logic [31:0] exp_prev_val;
    logic [2:0] exp_prev_d;

    rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_pc = '0;
    issue_imm = '0; issue_rob_id = '0; issue_rj = 1'b0; issue_rk = 1'b0;
    issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    lsb_to_rob = 1'b0; lsb_value = '0; lsb_dest = '0; clear_all = 1'b0;

    vecs.push_back('{OP_ADD,   32'd5,        32'd7,  32'd0,        32'd0,     32'd12});
    vecs.push_back('{OP_SUB,   32'd5,        32'd7,  32'd0,        32'd0,     32'hFFFFFFFE});
    vecs.push_back('{OP_SLL,   32'd1,        32'h21, 32'd0,        32'd0,     32'd2});
    vecs.push_back('{OP_SLT,   32'hFFFFFFFE, 32'd1,  32'd0,        32'd0,     32'd1});
    vecs.push_back('{OP_SLTU,  32'hFFFFFFFE, 32'd1,  32'd0,        32'd0,     32'd0});
    vecs.push_back('{OP_SRA,   32'h80000000, 32'd4,  32'd0,        32'd0,     32'hF8000000});
    vecs.push_back('{OP_SRL,   32'h80000000, 32'd31, 32'd0,        32'd0,     32'd1});
    vecs.push_back('{OP_XOR,   32'hF0F0,     32'h0FF0, 32'd0,      32'd0,     32'hFF00});
    vecs.push_back('{OP_LUI,   32'd9,        32'd9,  32'h12345000, 32'd0,     32'h12345000});
    vecs.push_back('{OP_AUIPC, 32'd0,        32'd0,  32'h2000,     32'h1000,  32'h3000});
    vecs.push_back('{OP_JAL,   32'd0,        32'd0,  32'h40,       32'h200,   32'h204});
    vecs.push_back('{OP_JALR,  32'h50,       32'd0,  32'h8,        32'h100,   32'h104});
    vecs.push_back('{OP_BLT,   32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,     32'd1});
    vecs.push_back('{OP_BLTU,  32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,     32'd0});
    vecs.push_back('{OP_BGE,   32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,     32'd0});
    vecs.push_back('{OP_BGEU,  32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,     32'd1});
    vecs.push_back('{OP_BEQ,   32'd3,        32'd3,  32'd0,        32'd0,     32'd1});
    vecs.push_back('{OP_ADDI,  32'd3,        32'd99, 32'd4,        32'd0,     32'd7});
    vecs.push_back('{OP_SRAI,  32'hFFFFFF00, 32'd0,  32'd4,        32'd0,     32'hFFFFFFF0});
    vecs.push_back('{OP_SLTIU, 32'd5,        32'd0,  32'hFFFFFFFF, 32'd0,     32'd1});
    vecs.push_back('{OP_ANDI,  32'hFF,       32'd0,  32'h0F,       32'd0,     32'h0F});
    vecs.push_back('{6'd63,    32'd1,        32'd1,  32'd1,        32'd1,     32'd0});

    // Reset state
    tick(); tick();
    rst_in = 1'b0;
    check("reset_to_rob", {31'd0, rs_to_rob}, 32'd0);
    check("reset_value", rs_value, 32'd0);
    check("reset_dest", {29'd0, rs_dest}, 32'd0);
    check("reset_full", {31'd0, rs_full}, 32'd0);

    // Ready ops: two-edge latency, one-cycle pulse
    for (int i = 0; i < vecs.size(); i++) begin
      logic [2:0] rob;
      rob = 3'(i);
      drive_issue(vecs[i].op, vecs[i].pc, vecs[i].imm, rob, 1'b1, vecs[i].vj, 3'd0,
                  1'b1, vecs[i].vk, 3'd0);
      tick(); idle();
      check("vec_early", {31'd0, rs_to_rob}, 32'd0);
      tick();
      check("vec_valid", {31'd0, rs_to_rob}, 32'd1);
      check("vec_value", rs_value, vecs[i].exp);
      check("vec_dest", {29'd0, rs_dest}, {29'd0, rob});
      tick();
      check("vec_pulse", {31'd0, rs_to_rob}, 32'd0);
    end

    // Pending operand woken by LSB
    do_reset();
    drive_issue(OP_SUB, 0, 0, 3'd3, 1'b0, 32'd0, 3'd4, 1'b1, 32'd1, 3'd0);
    tick(); idle(); tick(); tick();
    check("pend_wait", {31'd0, rs_to_rob}, 32'd0);
    lsb_to_rob = 1'b1; lsb_dest = 3'd4; lsb_value = 32'd10;
    tick(); lsb_to_rob = 1'b0;
    check("pend_no_same_edge", {31'd0, rs_to_rob}, 32'd0);
    tick();
    check("pend_valid", {31'd0, rs_to_rob}, 32'd1);
    check("pend_value", rs_value, 32'd9);
    check("pend_dest", {29'd0, rs_dest}, 32'd3);

    // Issue bypass from an LSB broadcast in the issue cycle
    tick();
    drive_issue(OP_SUB, 0, 0, 3'd2, 1'b0, 32'd0, 3'd5, 1'b1, 32'd1, 3'd0);
    lsb_to_rob = 1'b1; lsb_dest = 3'd5; lsb_value = 32'd20;
    tick(); idle(); lsb_to_rob = 1'b0;
    tick();
    check("byp_valid", {31'd0, rs_to_rob}, 32'd1);
    check("byp_value", rs_value, 32'd19);

    // LSB wins when both broadcasts match the same tag
    do_reset();
    drive_issue(OP_ADD, 0, 0, 3'd4, 1'b0, 32'd0, 3'd2, 1'b1, 32'd0, 3'd0);
    tick();
    drive_issue(OP_ADD, 0, 0, 3'd2, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    tick(); idle(); tick();
    check("prio_alu_dest", {29'd0, rs_dest}, 32'd2);
    lsb_to_rob = 1'b1; lsb_dest = 3'd2; lsb_value = 32'd50;
    tick(); lsb_to_rob = 1'b0;
    check("prio_gap", {31'd0, rs_to_rob}, 32'd0);
    tick();
    check("prio_value", rs_value, 32'd50);
    check("prio_dest", {29'd0, rs_dest}, 32'd4);

    // Full station, ignored 9th issue, index-ordered drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_issue(OP_ADD, 0, 0, 3'(i), 1'b0, 32'd0, 3'd6, 1'b1, 32'(i), 3'd0);
      tick();
    end
    check("full_set", {31'd0, rs_full}, 32'd1);
    drive_issue(OP_ADD, 0, 0, 3'd7, 1'b1, 32'd1, 3'd0, 1'b1, 32'd99, 3'd0);
    tick(); idle();
    check("full_ninth_ignored", {31'd0, rs_to_rob}, 32'd0);
    lsb_to_rob = 1'b1; lsb_dest = 3'd6; lsb_value = 32'd100;
    tick(); lsb_to_rob = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("drain_valid", {31'd0, rs_to_rob}, 32'd1);
      check("drain_value", rs_value, 32'd100 + 32'(k));
      check("drain_dest", {29'd0, rs_dest}, 32'(k));
    end
    tick();
    check("drain_done", {31'd0, rs_to_rob}, 32'd0);
    check("drain_full", {31'd0, rs_full}, 32'd0);

    // Chained dependency through the station's own result
    do_reset();
    drive_issue(OP_ADDI, 0, 32'd4, 3'd1, 1'b1, 32'd3, 3'd0, 1'b1, 32'd0, 3'd0);
    tick();
    drive_issue(OP_ADD, 0, 0, 3'd5, 1'b0, 32'd0, 3'd1, 1'b1, 32'd10, 3'd0);
    tick(); idle();
    check("chain_a_value", rs_value, 32'd7);
    check("chain_a_dest", {29'd0, rs_dest}, 32'd1);
    tick();
    check("chain_gap", {31'd0, rs_to_rob}, 32'd0);
    tick();
    check("chain_b_valid", {31'd0, rs_to_rob}, 32'd1);
    check("chain_b_value", rs_value, 32'd17);
    check("chain_b_dest", {29'd0, rs_dest}, 32'd5);

    // Pause with rdy_in low
    do_reset();
    drive_issue(OP_ADD, 0, 0, 3'd1, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0);
    tick();
    drive_issue(OP_ADD, 0, 0, 3'd2, 1'b1, 32'd10, 3'd0, 1'b1, 32'd20, 3'd0);
    tick(); idle();
    check("pause_x_value", rs_value, 32'd3);
    rdy_in = 1'b0;
    drive_issue(OP_ADD, 0, 0, 3'd3, 1'b1, 32'd100, 3'd0, 1'b1, 32'd100, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pause_valid", {31'd0, rs_to_rob}, 32'd1);
      check("pause_value", rs_value, 32'd3);
      check("pause_dest", {29'd0, rs_dest}, 32'd1);
    end
    idle(); rdy_in = 1'b1;
    tick();
    check("resume_value", rs_value, 32'd30);
    check("resume_dest", {29'd0, rs_dest}, 32'd2);
    tick();
    check("pause_issue_dropped", {31'd0, rs_to_rob}, 32'd0);

    // Flush with station full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_issue(OP_ADD, 0, 0, 3'(i), 1'b0, 32'd0, 3'd7, 1'b1, 32'd1, 3'd0);
      tick();
    end
    idle();
    check("flush_pre_full", {31'd0, rs_full}, 32'd1);
    clear_all = 1'b1;
    tick(); clear_all = 1'b0;
    check("flush_full", {31'd0, rs_full}, 32'd0);
    check("flush_to_rob", {31'd0, rs_to_rob}, 32'd0);
    lsb_to_rob = 1'b1; lsb_dest = 3'd7; lsb_value = 32'd5;
    tick(); lsb_to_rob = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_quiet", {31'd0, rs_to_rob}, 32'd0);
    end

    // Flush drops a same-cycle dispatch and issue
    drive_issue(OP_ADD, 0, 0, 3'd1, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    tick();
    drive_issue(OP_ADD, 0, 0, 3'd2, 1'b1, 32'd2, 3'd0, 1'b1, 32'd2, 3'd0);
    clear_all = 1'b1;
    tick(); clear_all = 1'b0; idle();
    check("flush_disp_dropped", {31'd0, rs_to_rob}, 32'd0);
    tick();
    check("flush_issue_dropped", {31'd0, rs_to_rob}, 32'd0);

    // Reset mid-operation
    drive_issue(OP_ADD, 0, 0, 3'd6, 1'b1, 32'd4, 3'd0, 1'b1, 32'd4, 3'd0);
    tick(); idle();
    rst_in = 1'b1;
    tick(); rst_in = 1'b0;
    check("midrst_to_rob", {31'd0, rs_to_rob}, 32'd0);
    check("midrst_value", rs_value, 32'd0);
    tick();
    check("midrst_no_result", {31'd0, rs_to_rob}, 32'd0);

    // Random ready ops, one-deep expected pipeline
    do_reset();
    exp_prev_v = 1'b0; exp_prev_val = '0; exp_prev_d = '0;
    for (int it = 0; it < 300; it++) begin
      logic       do_iss;
      logic [5:0] op;
      logic [31:0] a, b, imm, pc;
      logic [2:0] rob;
      do_iss = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 29));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = $urandom;
      pc  = $urandom;
      rob = 3'($urandom_range(0, 7));
      if (do_iss) drive_issue(op, pc, imm, rob, 1'b1, a, 3'd0, 1'b1, b, 3'd0);
      else idle();
      tick();
      check("rnd_valid", {31'd0, rs_to_rob}, {31'd0, exp_prev_v});
      if (exp_prev_v) begin
        check("rnd_value", rs_value, exp_prev_val);
        check("rnd_dest", {29'd0, rs_dest}, {29'd0, exp_prev_d});
      end
      exp_prev_v   = do_iss;
      exp_prev_val = ref_alu(op, a, b, imm, pc);
      exp_prev_d   = rob;
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
